// File: rtl/button_conditioner.sv
// Button conditioner: per-channel 2-FF synchronizer, debounce counter and
// rising-edge detector, followed by a pending/arbiter stage that issues at
// most one single-cycle press pulse per clock, lowest channel index first.
module button_conditioner #(
    parameter int unsigned NB_BTN          = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned NB_CNT          = 20
) (
    input  logic              clk,
    input  logic              i_reset_n,
    input  logic [NB_BTN-1:0] i_btn,
    output logic [NB_BTN-1:0] o_pulse,
    output logic [NB_BTN-1:0] o_level
);

    // Counter value on which a differing level has persisted long enough
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(DEBOUNCE_CYCLES - 1);

    logic [NB_BTN-1:0]             sync1_q;
    logic [NB_BTN-1:0]             sync2_q;
    logic [NB_BTN-1:0][NB_CNT-1:0] cnt_q;
    logic [NB_BTN-1:0][NB_CNT-1:0] cnt_d;
    logic [NB_BTN-1:0]             level_q;
    logic [NB_BTN-1:0]             level_d;
    logic [NB_BTN-1:0]             level_prev_q;
    logic [NB_BTN-1:0]             pending_q;
    logic [NB_BTN-1:0]             pending_d;
    logic [NB_BTN-1:0]             pulse_q;
    logic [NB_BTN-1:0]             rise_c;
    logic [NB_BTN-1:0]             grant_c;

    // Debounce: accept the synchronized level only after it has differed
    // from the stable level for DEBOUNCE_CYCLES consecutive edges
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        for (int unsigned i = 0; i < NB_BTN; i++) begin
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + NB_CNT'(1);
                end
            end
        end
    end

    // Edge detect, lowest-index grant and pending update; a new rise on a
    // channel being granted this cycle keeps its pending bit set
    always_comb begin
        rise_c    = level_q & ~level_prev_q;
        grant_c   = pending_q & (~pending_q + NB_BTN'(1));
        pending_d = (pending_q & ~grant_c) | rise_c;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            cnt_q        <= '0;
            level_q      <= '0;
            level_prev_q <= '0;
            pending_q    <= '0;
            pulse_q      <= '0;
        end else begin
            sync1_q      <= i_btn;
            sync2_q      <= sync1_q;
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            pending_q    <= pending_d;
            pulse_q      <= grant_c;
        end
    end

    assign o_pulse = pulse_q;
    assign o_level = level_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with a short debounce window.
module tb_button_conditioner;

    localparam int unsigned NB_BTN = 3;

    typedef struct {
        logic              rst_n;
        logic [NB_BTN-1:0] btn;
        logic [NB_BTN-1:0] pulse;
        logic [NB_BTN-1:0] level;
        string             name;
    } vec_t;

    logic              clk;
    logic              i_reset_n;
    logic [NB_BTN-1:0] i_btn;
    logic [NB_BTN-1:0] o_pulse;
    logic [NB_BTN-1:0] o_level;

    int   checks;
    int   errors;
    vec_t vecs[$];

    button_conditioner #(
        .NB_BTN         (NB_BTN),
        .DEBOUNCE_CYCLES(4),
        .NB_CNT         (3)
    ) dut (
        .clk      (clk),
        .i_reset_n(i_reset_n),
        .i_btn    (i_btn),
        .o_pulse  (o_pulse),
        .o_level  (o_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic rst_n, input logic [NB_BTN-1:0] btn,
                       input logic [NB_BTN-1:0] pulse, input logic [NB_BTN-1:0] level,
                       input string name);
        vec_t v;
        v.rst_n = rst_n;
        v.btn   = btn;
        v.pulse = pulse;
        v.level = level;
        v.name  = name;
        vecs.push_back(v);
    endtask

    // Drive inputs for the next edge, then sample 1 time unit after it
    task automatic step(input logic rst_n, input logic [NB_BTN-1:0] btn);
        i_reset_n = rst_n;
        i_btn     = btn;
        @(posedge clk);
        #1;
        checks++;
        if (!$onehot0(o_pulse)) begin
            errors++;
            $display("FAIL onehot: o_pulse=%b is multi-hot", o_pulse);
        end
    endtask

    task automatic check(input string name, input int idx,
                         input logic [NB_BTN-1:0] act, input logic [NB_BTN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
        end
    endtask

    initial begin
        int pulses;
        checks    = 0;
        errors    = 0;
        i_reset_n = 1'b0;
        i_btn     = '0;

        // 1: reset held with all buttons high
        for (int k = 0; k < 3; k++) add(1'b0, 3'b111, 3'b000, 3'b000, "reset");
        add(1'b0, 3'b000, 3'b000, 3'b000, "reset");

        // 2: single press on channel 0, held 20 cycles then released
        for (int k = 0; k < 33; k++) begin
            add(1'b1, (k < 20) ? 3'b001 : 3'b000, (k == 7) ? 3'b001 : 3'b000,
                (k >= 5 && k < 25) ? 3'b001 : 3'b000, "press0");
        end
        add(1'b0, 3'b000, 3'b000, 3'b000, "reset");

        // 3: bouncing channel 1, each high burst shorter than the window
        for (int k = 0; k < 20; k++) begin
            add(1'b1, ((k < 3) || (k >= 5 && k < 8)) ? 3'b010 : 3'b000,
                3'b000, 3'b000, "bounce1");
        end
        add(1'b0, 3'b000, 3'b000, 3'b000, "reset");

        // 4: all channels pressed together, served lowest index first
        for (int k = 0; k < 26; k++) begin
            logic [NB_BTN-1:0] p;
            p = 3'b000;
            if (k == 7) p = 3'b001;
            if (k == 8) p = 3'b010;
            if (k == 9) p = 3'b100;
            add(1'b1, (k < 15) ? 3'b111 : 3'b000, p,
                (k >= 5 && k < 20) ? 3'b111 : 3'b000, "simul");
        end
        add(1'b0, 3'b000, 3'b000, 3'b000, "reset");

        for (int n = 0; n < vecs.size(); n++) begin
            step(vecs[n].rst_n, vecs[n].btn);
            check({vecs[n].name, "_pulse"}, n, o_pulse, vecs[n].pulse);
            check({vecs[n].name, "_level"}, n, o_level, vecs[n].level);
        end

        // 5: reset pulse at edge 6 while channel 2 is held; the pending press
        // is dropped and the still-held button re-qualifies from scratch
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 3'b100);
            check("rst_mid_pulse", k, o_pulse, 3'b000);
            check("rst_mid_level", k, o_level, (k >= 5) ? 3'b100 : 3'b000);
        end
        step(1'b0, 3'b100);
        check("rst_edge_pulse", 6, o_pulse, 3'b000);
        check("rst_edge_level", 6, o_level, 3'b000);
        // m counts edges after the reset edge; m=1 is the first post-reset sample
        for (int m = 1; m <= 15; m++) begin
            step(1'b1, 3'b100);
            check("rst_after_pulse", m, o_pulse, (m == 8) ? 3'b100 : 3'b000);
            check("rst_after_level", m, o_level, (m >= 6) ? 3'b100 : 3'b000);
        end
        step(1'b0, 3'b000);

        // 6: long hold yields exactly one pulse
        pulses = 0;
        for (int k = 0; k < 1000; k++) begin
            step(1'b1, 3'b001);
            if (o_pulse != 3'b000) pulses++;
            check("hold_pulse", k, o_pulse, (k == 7) ? 3'b001 : 3'b000);
        end
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 3'b000);
            if (o_pulse != 3'b000) pulses++;
        end
        check("hold_level_released", 0, o_level, 3'b000);
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL hold_count: got %0d pulses expected 1", pulses);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
